// File: rtl/cpu_datapath.sv
// Register-and-bus datapath for the 8-bit accumulator CPU: PC/AR/DR/AC/IR, shared bus mux,
// accumulator ALU with carry flag, and the external memory address/data interface.
module cpu_datapath #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             loadPC,
    input  logic             incPC,
    input  logic             clearPC,
    input  logic             loadAR,
    input  logic             incAR,
    input  logic             clearAR,
    input  logic             loadDR,
    input  logic             incDR,
    input  logic             clearDR,
    input  logic             loadAC,
    input  logic             incAC,
    input  logic             clearAC,
    input  logic             loadIR,
    input  logic             incIR,
    input  logic             clearIR,
    input  logic [2:0]       busSelectors,
    input  logic [2:0]       aluOpcode,
    input  logic             read,
    input  logic             write,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    output logic [WIDTH-1:0] IR,
    output logic [WIDTH-1:0] bus,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [2:0] {
        OpAdd   = 3'd0,
        OpAshl  = 3'd1,
        OpXnor  = 3'd2,
        OpDiv2  = 3'd3,
        OpLoad  = 3'd4,
        OpStore = 3'd5,
        OpComp  = 3'd6,
        OpRound = 3'd7
    } alu_op_e;

    logic [WIDTH-1:0] pc_q, ar_q, dr_q, ac_q, ir_q;
    logic [WIDTH-1:0] pc_d, ar_d, dr_d, ac_d, ir_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_c_we;
    logic [WIDTH:0]   sum;

    // read carries no state; the bus source is chosen by busSelectors alone
    logic unused_read;
    assign unused_read = read;

    always_comb begin
        bus = '0;
        unique case (busSelectors)
            3'd1:    bus = ar_q;
            3'd2:    bus = pc_q;
            3'd3:    bus = dr_q;
            3'd4:    bus = ac_q;
            3'd5:    bus = ir_q;
            3'd7:    bus = mem_rdata;
            default: bus = '0;
        endcase
    end

    always_comb begin
        alu_r    = '0;
        alu_c    = carry_q;
        alu_c_we = 1'b0;
        sum      = '0;
        unique case (alu_op_e'(aluOpcode))
            OpAdd: begin
                sum      = {1'b0, ac_q} + {1'b0, dr_q};
                alu_r    = sum[WIDTH-1:0];
                alu_c    = sum[WIDTH];
                alu_c_we = 1'b1;
            end
            OpAshl: begin
                alu_r    = {dr_q[WIDTH-2:0], 1'b0};
                alu_c    = dr_q[WIDTH-1];
                alu_c_we = 1'b1;
            end
            OpXnor:  alu_r = ~(ac_q ^ dr_q);
            OpDiv2: begin
                alu_r    = {dr_q[WIDTH-1], dr_q[WIDTH-1:1]};
                alu_c    = dr_q[0];
                alu_c_we = 1'b1;
            end
            OpLoad:  alu_r = dr_q;
            OpStore: alu_r = ac_q;
            OpComp:  alu_r = ~dr_q + WIDTH'(1);
            OpRound: begin
                sum      = {1'b0, ac_q} + {{WIDTH{1'b0}}, dr_q[WIDTH-1]};
                alu_r    = sum[WIDTH-1:0];
                alu_c    = sum[WIDTH];
                alu_c_we = 1'b1;
            end
            default: alu_r = '0;
        endcase
    end

    // clear beats load beats increment
    function automatic logic [WIDTH-1:0] next_reg(input logic clr, input logic ld,
                                                  input logic inc, input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] d);
        if (clr)      return '0;
        else if (ld)  return d;
        else if (inc) return q + WIDTH'(1);
        else          return q;
    endfunction

    always_comb begin
        pc_d    = next_reg(clearPC, loadPC, incPC, pc_q, bus);
        ar_d    = next_reg(clearAR, loadAR, incAR, ar_q, bus);
        dr_d    = next_reg(clearDR, loadDR, incDR, dr_q, bus);
        ac_d    = next_reg(clearAC, loadAC, incAC, ac_q, alu_r);
        ir_d    = next_reg(clearIR, loadIR, incIR, ir_q, bus);
        carry_d = (loadAC && alu_c_we) ? alu_c : carry_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= '0;
            ar_q    <= '0;
            dr_q    <= '0;
            ac_q    <= '0;
            ir_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ar_q    <= ar_d;
            dr_q    <= dr_d;
            ac_q    <= ac_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
        end
    end

    assign mem_addr  = ar_q;
    assign mem_wdata = ac_q;
    assign mem_we    = write;
    assign IR        = ir_q;
    assign carry     = carry_q;
    assign zero      = (ac_q == '0);

endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

Register-and-bus datapath of the 8-bit accumulator CPU, sitting directly downstream of the instruction controller. It holds PC, AR, DR, AC and IR, drives the shared 8-bit bus from the 3-bit bus select, and applies the per-register load/increment/clear strobes on each clock edge. It also hosts the accumulator ALU (selected by the 3-bit ALU opcode), a carry flag, and the memory address/write-data interface. IR is fed back to the controller for decoding.

## Interface
- WIDTH, 8: data, address and register width (all registers WIDTH bits)
- clk  in  1  single system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears every register and flag
- loadPC/incPC/clearPC, loadAR/incAR/clearAR, loadDR/incDR/clearDR, loadAC/incAC/clearAC, loadIR/incIR/clearIR  in  1 each  register strobes
- busSelectors  in  3  bus source select
- aluOpcode  in  3  ALU function
- read  in  1  memory read cycle (bus source is mem_rdata)
- write  in  1  memory write strobe
- mem_rdata  in  WIDTH  combinational read data for address mem_addr
- mem_addr  out  WIDTH  equals AR
- mem_wdata  out  WIDTH  equals AC
- mem_we  out  1  equals write
- IR  out  WIDTH  instruction register to controller
- bus  out  WIDTH  current bus value (debug/observation)
- carry  out  1  carry flag register
- zero  out  1  combinational, 1 when AC == 0

## Operation
- Bus mux (combinational): sel 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 7 mem_rdata, 0 and 6 drive 0.
- PC, AR, DR, IR load from bus; AC loads from ALU result.
- Per-register priority on a given edge: clear > load > inc; none asserted = hold.
- inc is +1 modulo 2^WIDTH (0xFF -> 0x00, no flag change).
- ALU operands A = AC, B = DR; result R (WIDTH bits):
  - 0 ADD: R = A+B; carry <= bit WIDTH of sum
  - 1 ASHL: R = {B[W-2:0],0}; carry <= B[W-1]
  - 2 XNOR: R = ~(A^B)
  - 3 DIV2: R = {B[W-1],B[W-1:1]} (arithmetic shift right); carry <= B[0]
  - 4 LOAD: R = B
  - 5 STORE: R = A (AC unchanged if loaded)
  - 6 COMP: R = ~B + 1 (two's complement)
  - 7 ROUND: R = A + (B[W-1] ? 1 : 0); carry <= carry-out
- carry updates only on edges where loadAC=1 and opcode is ADD/ASHL/DIV2/ROUND; otherwise holds. clearAC does not clear carry.
- Memory write is external: mem_we = write, address AR, data AC, all combinational from current registers.
- read only qualifies the bus; no internal state. read=1 with busSelectors≠7 is a controller fault: bus still follows busSelectors.

## Timing
- Reset (synchronous): after the edge with reset=1, PC=AR=DR=AC=IR=0, carry=0; reset overrides all strobes on that edge. Outputs therefore: mem_addr=0, mem_wdata=0, IR=0, zero=1, bus per busSelectors (0 when sel=0).
- Register updates visible one cycle after strobe (value sampled from bus/ALU in the same cycle as the strobe).
- Bus, mem_addr, mem_wdata, mem_we, zero: zero-latency combinational.
- Same-cycle read-and-load: register loading from bus in the cycle it is on the bus gets its old value (e.g. sel=3 with loadDR=1 keeps DR).
- AC loading from ALU when ALU reads AC uses pre-edge AC.
- Fetch sequence from controller: T0 AR<=PC; T1 IR<=M[AR], PC++; T2 AR<=IR; each takes exactly one edge.

## Test plan
- Reset: preload all regs to 0x5A, assert reset with loadAC=incPC=1 -> all regs 0x00, carry 0, zero 1 next cycle.
- Fetch: PC=0x10, mem[0x10]=0x9C; sel=2+loadAR, then sel=7+read+loadIR+incPC -> AR=0x10, IR=0x9C, PC=0x11.
- ADD carry: AC=0xF0, DR=0x20, op 0, loadAC -> AC=0x10, carry=1; then op 2 -> carry stays 1, AC=~(0x10^0x20)=0xCF.
- Shifts/COMP: DR=0x81: op 1 -> AC=0x02 carry 1; op 3 -> AC=0xC0 carry 1; op 6 -> AC=0x7F.
- Priority/wrap: PC=0xFF incPC -> 0x00; clearAR+loadAR+incAR same edge -> AR=0x00; loadDR+incDR with bus 0x33 -> DR=0x33.
- Store: AR=0x40, AC=0x77, write=1, sel=4 -> mem_we=1, mem_addr=0x40, mem_wdata=0x77, bus=0x77; sel=0/6 -> bus=0x00.
